// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction-memory read port plus the decode-side
// instruction handshake. master = fetch controller, slave = memory/decode.
interface fetch_ctrl_if #(
  parameter int AW = 5
) ();
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;

  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output inst_valid,
    input  inst_ready,
    output inst_pc,
    output inst_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  inst_valid,
    output inst_ready,
    input  inst_pc,
    input  inst_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-outstanding instruction fetch sequencer. Issues one
// word read at a time, holds the returned instruction until decode takes
// it, and throws away any response made stale by a redirect.
//
//   state | meaning
//   IDLE  | fetch disabled, no request, nothing outstanding
//   REQ   | imem_req high, waiting for imem_gnt
//   WAIT  | read granted, waiting for imem_rvalid
//   HOLD  | instruction presented on inst_valid until inst_ready
//   DROP  | granted read is stale, swallow its response
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          AW       = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  fetch_ctrl_if.master bus,
  output logic [31:0]  fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] issued_pc;
  logic [31:0] redirect_target;
  logic [31:0] inst_pc_q;
  logic [31:0] inst_data_q;
  logic        req_q;
  logic        valid_q;
  // Goes high one edge after reset release so the first request cannot
  // appear until the second rising edge, whatever en does during release.
  logic        started;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc[AW+1:2];
  assign bus.inst_valid = valid_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_data  = inst_data_q;

  // Fetch FSM with registered request/valid outputs, pc tracking and delivery count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      issued_pc   <= '0;
      started     <= 1'b0;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      inst_pc_q   <= '0;
      inst_data_q <= '0;
      fetch_count <= '0;
    end else begin
      started <= 1'b1;

      // Delivery counts whenever the handshake completes, even on a redirect cycle.
      if (valid_q && bus.inst_ready) begin
        fetch_count <= fetch_count + 32'd1;
      end

      // A redirect always wins the pc; a later one simply overwrites an earlier one.
      if (redirect_valid) begin
        pc <= redirect_target;
      end

      case (state)
        S_IDLE: begin
          if (en && started) begin
            state <= S_REQ;
            req_q <= 1'b1;
          end
        end

        S_REQ: begin
          // en is ignored here: a raised request is never withdrawn.
          if (bus.imem_gnt) begin
            req_q <= 1'b0;
            if (redirect_valid) begin
              state <= S_DROP;
            end else begin
              issued_pc <= pc;
              pc        <= pc + 32'd4;
              state     <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            if (bus.imem_rvalid) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_DROP;
            end
          end else if (bus.imem_rvalid) begin
            inst_pc_q   <= issued_pc;
            inst_data_q <= bus.imem_rdata;
            valid_q     <= 1'b1;
            state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (redirect_valid || bus.inst_ready) begin
            valid_q <= 1'b0;
            if (redirect_valid || en) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        S_DROP: begin
          if (bus.imem_rvalid) begin
            if (en) begin
              state <= S_REQ;
              req_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- AW, 5, instruction-memory word-address width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, asynchronous active-low reset.
- en, in, 1, fetch enable.
- redirect_valid, in, 1, branch/jump redirect strobe.
- redirect_pc, in, 32, redirect target.
- imem_req, out, 1, memory read request.
- imem_addr, out, AW, word address, = pc[AW+1:2].
- imem_gnt, in, 1, request accepted this cycle.
- imem_rvalid, in, 1, read data valid.
- imem_rdata, in, 32, read data.
- inst_valid, out, 1, instruction available to decode.
- inst_ready, in, 1, decode accepts instruction.
- inst_pc, out, 32, PC of inst_data.
- inst_data, out, 32, fetched instruction.
- fetch_count, out, 32, delivered-instruction counter.
REQ-003 One clock; reset SHALL be asynchronous and active-low on rst, and all state SHALL be clocked on clk.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, HOLD and DROP.
REQ-005 IDLE: imem_req=0; next state REQ when en=1, else stay IDLE.
REQ-006 REQ: imem_req=1, imem_addr=pc[AW+1:2]. On imem_gnt=1: latch issued_pc=pc, set pc<=pc+4, go to WAIT.
REQ-007 Once asserted, imem_req SHALL stay high until imem_gnt; en=0 SHALL NOT withdraw a pending request.
REQ-008 At most one memory transaction SHALL be outstanding; responses SHALL arrive in order, at least 1 cycle after grant.
REQ-009 WAIT: on imem_rvalid=1, load inst_data=imem_rdata and inst_pc=issued_pc, then go to HOLD.
REQ-010 HOLD: inst_valid=1, with inst_pc and inst_data stable. On inst_ready=1, go to REQ if en=1, else IDLE.
REQ-011 inst_valid SHALL be 1 only in HOLD; inst_valid SHALL NOT depend combinationally on inst_ready.
REQ-012 Redirect: redirect_valid=1 in any state SHALL set pc<=redirect_pc with bits [1:0] forced to 0.
REQ-013 Redirect handling per state:
- IDLE: pc updated, state stays IDLE unless en=1.
- REQ without gnt: the new address is presented on imem_addr the next cycle.
- REQ with gnt in the same cycle: the granted read is stale, go to DROP.
- WAIT without rvalid: go to DROP.
- WAIT with rvalid: discard the data, go to REQ.
- HOLD: inst_valid drops next cycle, go to REQ. A simultaneous inst_ready SHALL still count as delivered.
REQ-014 DROP: imem_req=0 and inst_valid=0. On imem_rvalid, discard the data and go to REQ if en=1, else IDLE.
REQ-015 A later redirect SHALL override an earlier one; only the last redirect_pc before the next grant is fetched.
REQ-016 pc arithmetic SHALL be modulo 2^32 (32'hFFFF_FFFC+4=0). imem_addr SHALL wrap naturally at 2^AW words.
REQ-017 fetch_count SHALL increment by 1 on each cycle with inst_valid&inst_ready, wrapping modulo 2^32.
REQ-018 Throughput: with gnt and rvalid each arriving 1 cycle after being awaited, one instruction SHALL be delivered every 3 cycles.

Reset
REQ-019 While rst=0, regardless of clk:
- state=IDLE, pc=RESET_PC, issued_pc=0
- imem_req=0, imem_addr=RESET_PC[AW+1:2]
- inst_valid=0, inst_pc=0, inst_data=0, fetch_count=0
REQ-020 Reset asserted mid-transaction SHALL abandon it. A response arriving after reset release while in IDLE/REQ SHALL be ignored.
REQ-021 The first imem_req SHALL assert no earlier than the 2nd rising clk edge after rst rises with en=1.

Verification
REQ-022 Reset, then en=1, gnt and rvalid each 1 cycle late, inst_ready=1, memory word n = 32'h1000_0000+n:
- inst_pc sequence SHALL be 0,4,8.
- inst_data sequence SHALL be 32'h1000_0000, 32'h1000_0001, 32'h1000_0002.
- fetch_count SHALL read 3.
REQ-023 Hold inst_ready=0 for 5 cycles in HOLD (inst_pc=4): inst_valid, inst_pc and inst_data stay stable, imem_req=0, fetch_count unchanged.
REQ-024 Redirect to 32'h0000_0043 while in WAIT: the returned data is discarded, and the next imem_req has imem_addr=5'd16 with inst_pc=32'h40.
REQ-025 Redirect coinciding with imem_gnt in REQ: DROP is entered, exactly one response is discarded, and no inst_valid occurs for the stale PC.
REQ-026 RESET_PC=32'hFFFF_FFFC: inst_pc sequence SHALL be 32'hFFFF_FFFC then 0; imem_addr sequence SHALL be 31 then 0.
REQ-027 Drop en in REQ while gnt is withheld for 3 cycles: imem_req stays 1 until gnt, then one instruction is delivered and the FSM returns to IDLE.
